// File: rtl/fig8_sequencer_if.sv
// Command/status bundle between the command logic (master) and the figure-8 sequencer (slave).
interface fig8_sequencer_if #(
   parameter int unsigned LAP_W = 4,
   parameter int unsigned TMO_W = 16
);
   logic             go;
   logic             stop_req;
   logic             pause;
   logic             init_ack;
   logic             song_ack;
   logic             seg_done;
   logic [LAP_W-1:0] laps;
   logic [TMO_W-1:0] seg_timeout;
   logic [2:0]       state;
   logic [1:0]       dir;
   logic [LAP_W-1:0] lap_cnt;
   logic             busy;
   logic             done;
   logic             fault;

   modport master (
      output go, stop_req, pause, init_ack, song_ack, seg_done, laps, seg_timeout,
      input  state, dir, lap_cnt, busy, done, fault
   );

   modport slave (
      input  go, stop_req, pause, init_ack, song_ack, seg_done, laps, seg_timeout,
      output state, dir, lap_cnt, busy, done, fault
   );
endinterface

// File: rtl/fig8_sequencer.sv
// Figure-8 drive sequencer: INIT/SONG startup, counted or continuous CW/CCW laps,
// pause/resume, abort and a per-segment watchdog that parks the robot in FAULT.
module fig8_sequencer #(
   parameter int unsigned LAP_W = 4,
   parameter int unsigned TMO_W = 16
) (
   input logic             clk,
   input logic             rst,
   fig8_sequencer_if.slave bus
);
   localparam logic [2:0] S_STOP  = 3'd0;
   localparam logic [2:0] S_CW    = 3'd1;
   localparam logic [2:0] S_CCW   = 3'd2;
   localparam logic [2:0] S_INIT  = 3'd3;
   localparam logic [2:0] S_SONG  = 3'd4;
   localparam logic [2:0] S_PAUSE = 3'd5;
   localparam logic [2:0] S_FAULT = 3'd6;

   localparam logic [1:0] DIR_STOP = 2'b00;
   localparam logic [1:0] DIR_CW   = 2'b01;
   localparam logic [1:0] DIR_CCW  = 2'b10;

   logic [2:0]       state_q, state_nxt;
   logic [2:0]       resume_q, resume_nxt;
   logic [LAP_W-1:0] lap_q, lap_nxt, lap_inc;
   logic [LAP_W-1:0] tgt_q, tgt_nxt;
   logic [TMO_W-1:0] wd_q, wd_nxt;
   logic [1:0]       dir_nxt;
   logic             busy_nxt, done_nxt, fault_nxt;
   logic             wd_expired;

   assign lap_inc    = lap_q + LAP_W'(1);
   assign wd_expired = (bus.seg_timeout != '0) && (wd_q == bus.seg_timeout);

   // Next state, counters and decoded outputs for the next cycle
   always_comb begin
      state_nxt  = state_q;
      resume_nxt = resume_q;
      lap_nxt    = lap_q;
      tgt_nxt    = tgt_q;
      done_nxt   = 1'b0;
      wd_nxt     = '0;
      dir_nxt    = DIR_STOP;

      if (bus.stop_req && (state_q != S_STOP)) begin
         state_nxt = S_STOP;
      end else begin
         case (state_q)
            S_STOP: begin
               if (bus.go) begin
                  state_nxt = S_INIT;
                  tgt_nxt   = bus.laps;
                  lap_nxt   = '0;
               end
            end
            S_INIT:  if (bus.init_ack) state_nxt = S_SONG;
            S_SONG:  if (bus.song_ack) state_nxt = S_CW;
            S_CW, S_CCW: begin
               if (bus.seg_done) begin
                  if (state_q == S_CW) begin
                     state_nxt = S_CCW;
                  end else begin
                     lap_nxt = lap_inc;
                     if ((tgt_q != '0) && (lap_inc == tgt_q)) begin
                        state_nxt = S_STOP;
                        done_nxt  = 1'b1;
                     end else begin
                        state_nxt = S_CW;
                     end
                  end
               end else if (wd_expired) begin
                  state_nxt = S_FAULT;
               end else if (bus.pause) begin
                  state_nxt  = S_PAUSE;
                  resume_nxt = state_q;
               end
            end
            S_PAUSE: if (!bus.pause) state_nxt = resume_q;
            S_FAULT: ;
            default: state_nxt = S_STOP;
         endcase
      end

      // Watchdog restarts on every segment entry, counts while the segment is held
      if (((state_nxt == S_CW) || (state_nxt == S_CCW)) && (state_nxt == state_q)) begin
         wd_nxt = wd_q + TMO_W'(1);
      end

      case (state_nxt)
         S_CW:    dir_nxt = DIR_CW;
         S_CCW:   dir_nxt = DIR_CCW;
         default: dir_nxt = DIR_STOP;
      endcase
      busy_nxt  = (state_nxt != S_STOP) && (state_nxt != S_FAULT);
      fault_nxt = (state_nxt == S_FAULT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_STOP;
         resume_q  <= S_CW;
         lap_q     <= '0;
         tgt_q     <= '0;
         wd_q      <= '0;
         bus.dir   <= DIR_STOP;
         bus.busy  <= 1'b0;
         bus.done  <= 1'b0;
         bus.fault <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         resume_q  <= resume_nxt;
         lap_q     <= lap_nxt;
         tgt_q     <= tgt_nxt;
         wd_q      <= wd_nxt;
         bus.dir   <= dir_nxt;
         bus.busy  <= busy_nxt;
         bus.done  <= done_nxt;
         bus.fault <= fault_nxt;
      end
   end

   assign bus.state   = state_q;
   assign bus.lap_cnt = lap_q;
endmodule

// File: tb/tb_fig8_sequencer.sv
// Bench for fig8_sequencer: directed scenarios plus random stimulus, all checked
// every cycle against a behavioural model of the sequencing rules.
`timescale 1ns/1ps
module tb_fig8_sequencer;
   localparam int unsigned LAP_W = 2;
   localparam int unsigned TMO_W = 8;
   localparam int TMO_MOD = 1 << TMO_W;
   localparam int LAP_MOD = 1 << LAP_W;
   localparam int ST_STOP = 0, ST_CW = 1, ST_CCW = 2, ST_INIT = 3, ST_SONG = 4, ST_PAUSE = 5, ST_FAULT = 6;

   logic clk = 1'b0;
   logic rst;

   fig8_sequencer_if #(.LAP_W(LAP_W), .TMO_W(TMO_W)) bus ();
   fig8_sequencer #(.LAP_W(LAP_W), .TMO_W(TMO_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: state as a plain int, watchdog as "cycles since segment entry"
   int m_state = ST_STOP, m_resume = ST_CW, m_age = 0, m_lap = 0, m_tgt = 0, m_done_cnt = 0;
   bit m_done = 1'b0;
   int trace[$];
   int lap_trace[$];

   task automatic model_step();
      int nxt;
      int lap_n;
      bit done_n;
      if (rst) begin
         m_state = ST_STOP; m_resume = ST_CW; m_age = 0; m_lap = 0; m_tgt = 0; m_done = 1'b0;
         return;
      end
      nxt = m_state; lap_n = m_lap; done_n = 1'b0;
      if (m_state != ST_STOP && bus.stop_req) nxt = ST_STOP;
      else case (m_state)
         ST_STOP: if (bus.go) begin nxt = ST_INIT; m_tgt = int'(bus.laps); lap_n = 0; end
         ST_INIT: if (bus.init_ack) nxt = ST_SONG;
         ST_SONG: if (bus.song_ack) nxt = ST_CW;
         ST_CW, ST_CCW: begin
            if (bus.seg_done) begin
               if (m_state == ST_CW) nxt = ST_CCW;
               else begin
                  lap_n = (m_lap + 1) % LAP_MOD;
                  if (m_tgt != 0 && m_lap + 1 == m_tgt) begin nxt = ST_STOP; done_n = 1'b1; end
                  else nxt = ST_CW;
               end
            end else if (bus.seg_timeout != 0 && (m_age % TMO_MOD) == int'(bus.seg_timeout)) begin
               nxt = ST_FAULT;
            end else if (bus.pause) begin
               nxt = ST_PAUSE; m_resume = m_state;
            end
         end
         ST_PAUSE: if (!bus.pause) nxt = m_resume;
         default: ;
      endcase
      if (nxt == ST_CW || nxt == ST_CCW) m_age = (nxt == m_state) ? m_age + 1 : 0;
      else m_age = 0;
      if (nxt != m_state) trace.push_back(nxt);
      if (lap_n != m_lap) lap_trace.push_back(lap_n);
      m_state = nxt; m_lap = lap_n; m_done = done_n;
      if (done_n) m_done_cnt++;
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      model_step();
   end

   // Per-cycle comparison of every DUT output against the model
   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         int e_dir;
         e_dir = (m_state == ST_CW) ? 1 : (m_state == ST_CCW) ? 2 : 0;
         chk("state",   bus.state,   m_state);
         chk("dir",     bus.dir,     e_dir);
         chk("lap_cnt", bus.lap_cnt, m_lap);
         chk("busy",    bus.busy,    (m_state != ST_STOP && m_state != ST_FAULT) ? 1 : 0);
         chk("done",    bus.done,    m_done ? 1 : 0);
         chk("fault",   bus.fault,   (m_state == ST_FAULT) ? 1 : 0);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_seg();
      bus.seg_done = 1'b1; cyc(1); bus.seg_done = 1'b0;
   endtask

   task automatic pulse_stop();
      bus.stop_req = 1'b1; cyc(1); bus.stop_req = 1'b0;
   endtask

   task automatic reset_dut();
      rst = 1'b1; cyc(2); rst = 1'b0;
      chk("rst_state", bus.state, 0);
      chk("rst_dir",   bus.dir,   0);
      chk("rst_lap",   bus.lap_cnt, 0);
      chk("rst_flags", {bus.busy, bus.done, bus.fault}, 0);
      trace.delete(); lap_trace.delete(); m_done_cnt = 0;
   endtask

   task automatic start(input int laps, input int tmo);
      bus.laps = LAP_W'(laps); bus.seg_timeout = TMO_W'(tmo);
      bus.go = 1'b1;       cyc(1); bus.go = 1'b0;
      bus.init_ack = 1'b1; cyc(1); bus.init_ack = 1'b0;
      bus.song_ack = 1'b1; cyc(1); bus.song_ack = 1'b0;
   endtask

   initial begin
      int exp_tr[7]  = '{3, 4, 1, 2, 1, 2, 0};
      int exp_lap[5] = '{1, 2, 3, 0, 1};
      int exp_pz[6]  = '{3, 4, 1, 2, 5, 2};
      int cnt;
      bit saw_stop;
      {bus.go, bus.stop_req, bus.pause, bus.init_ack, bus.song_ack, bus.seg_done} = '0;
      bus.laps = '0; bus.seg_timeout = '0;
      reset_dut();
      cmp_en = 1'b1;

      // Normal two-lap run
      start(2, 0);
      chk("first_dir_cw", bus.dir, 1);
      repeat (4) begin cyc(9); pulse_seg(); end
      cyc(3);
      chk("norm_trace_len", trace.size(), 7);
      for (int i = 0; i < 7 && i < trace.size(); i++) chk("norm_trace", trace[i], exp_tr[i]);
      chk("norm_lap", m_lap, 2);
      chk("norm_done_cnt", m_done_cnt, 1);
      chk("norm_busy_after", bus.busy, 0);

      // Continuous mode wraps modulo 2^LAP_W
      reset_dut();
      start(0, 0);
      repeat (10) begin cyc(2); pulse_seg(); end
      cyc(2);
      chk("wrap_len", lap_trace.size(), 5);
      for (int i = 0; i < 5 && i < lap_trace.size(); i++) chk("wrap_lap", lap_trace[i], exp_lap[i]);
      saw_stop = 1'b0;
      foreach (trace[i]) if (trace[i] == ST_STOP) saw_stop = 1'b1;
      chk("wrap_no_stop", saw_stop, 0);
      chk("wrap_no_done", m_done_cnt, 0);
      pulse_stop();

      // Pause in CCW with an ignored seg_done
      reset_dut();
      start(3, 0);
      pulse_seg(); cyc(2);
      bus.pause = 1'b1; cyc(2);
      chk("pause_state", bus.state, ST_PAUSE);
      pulse_seg(); cyc(2);
      bus.pause = 1'b0; cyc(2);
      chk("pause_trace_len", trace.size(), 6);
      for (int i = 0; i < 6 && i < trace.size(); i++) chk("pause_trace", trace[i], exp_pz[i]);
      chk("pause_lap", m_lap, 0);
      pulse_stop();

      // Watchdog expiry after one completed lap
      reset_dut();
      start(3, 20);
      cyc(5); pulse_seg(); cyc(5); pulse_seg();
      cnt = 0;
      while (m_state != ST_FAULT && cnt < 100) begin cyc(1); cnt++; end
      chk("wd_latency", cnt, 21);
      chk("wd_fault_out", bus.fault, 1);
      cyc(3);
      pulse_stop();
      chk("wd_stop_state", m_state, ST_STOP);
      chk("wd_stop_lap", m_lap, 1);

      // seg_done on the expiry cycle wins over the watchdog
      reset_dut();
      start(3, 20);
      cyc(20); pulse_seg();
      chk("wd_edge_ccw", m_state, ST_CCW);
      chk("wd_edge_fault", bus.fault, 0);
      pulse_stop();

      // stop_req beats seg_done on the final lap
      reset_dut();
      start(1, 0);
      cyc(3); pulse_seg(); cyc(3);
      bus.stop_req = 1'b1; bus.seg_done = 1'b1; cyc(1);
      bus.stop_req = 1'b0; bus.seg_done = 1'b0;
      chk("abort_state", m_state, ST_STOP);
      chk("abort_lap", m_lap, 0);
      chk("abort_done", m_done_cnt, 0);
      cyc(2);

      // Asynchronous reset mid-CW on lap 2
      reset_dut();
      start(2, 0);
      pulse_seg(); pulse_seg(); cyc(3);
      @(posedge clk); #2 rst = 1'b1;
      #1;
      chk("arst_state", bus.state, 0);
      chk("arst_dir",   bus.dir, 0);
      chk("arst_lap",   bus.lap_cnt, 0);
      #1 rst = 1'b0;
      @(negedge clk);
      trace.delete();
      start(2, 0);
      chk("arst_restart", (trace.size() > 0) ? trace[0] : -1, ST_INIT);
      pulse_stop();

      // Random stimulus
      reset_dut();
      for (int i = 0; i < 2500; i++) begin
         if (i % 250 == 0)
            bus.seg_timeout = ($urandom_range(0, 2) == 0) ? TMO_W'(0) : TMO_W'($urandom_range(4, 30));
         bus.laps     = LAP_W'($urandom_range(0, 3));
         bus.go       = ($urandom_range(0, 3) == 0);
         bus.init_ack = ($urandom_range(0, 2) == 0);
         bus.song_ack = ($urandom_range(0, 2) == 0);
         bus.seg_done = ($urandom_range(0, 4) == 0);
         bus.stop_req = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 7) == 0) bus.pause = ~bus.pause;
         cyc(1);
      end
      {bus.go, bus.stop_req, bus.pause, bus.init_ack, bus.song_ack, bus.seg_done} = '0;
      cyc(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
